// File: rtl/uart_string_rx.sv
// UART receiver (8N1) that assembles received bytes into strings of up to 128 bytes.
// A string ends on LF, on reaching 128 bytes, or after IDLE_BITS bit periods of line idle.
module uart_string_rx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200,
  parameter int unsigned IDLE_BITS = 20
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          uart_rx_port,
  output logic [1023:0] rx_string,
  output logic [7:0]    rx_length,
  output logic          rx_busy,
  output logic          rx_done,
  output logic          rx_err
);

  localparam int unsigned BAUD_DIV   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_DIV   = BAUD_DIV / 2;
  localparam int unsigned IDLE_LIMIT = IDLE_BITS * BAUD_DIV;
  localparam int unsigned CNT_W      = $clog2(BAUD_DIV + 1);
  localparam int unsigned IDLE_W     = $clog2(IDLE_LIMIT + 1);

  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t              state;
  logic                sync1;
  logic                rx_s;
  logic                rx_prev;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shift_reg;
  logic                byte_vld;
  logic [7:0]          byte_data;
  logic                start_ok;

  logic [1023:0]       work_buf;
  logic [7:0]          count;
  logic                full;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                fall_edge;
  logic                idle_run;
  logic                terminate;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= uart_rx_port;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  assign fall_edge = rx_prev & ~rx_s;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      byte_vld  <= 1'b0;
      byte_data <= '0;
      start_ok  <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      start_ok <= 1'b0;
      rx_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (fall_edge) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state    <= S_DATA;
              bit_idx  <= '0;
              start_ok <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt       <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              byte_vld  <= 1'b1;
              byte_data <= shift_reg;
              state     <= S_IDLE;
            end else begin
              rx_err <= 1'b1;
              state  <= S_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Idle timer only runs between bytes of a non-empty string
  assign idle_run  = (state == S_IDLE) && (count != 8'd0) && !fall_edge;
  assign terminate = full || (byte_vld && byte_data == 8'h0A) ||
                     (idle_run && idle_cnt == IDLE_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      work_buf  <= '0;
      count     <= '0;
      full      <= 1'b0;
      idle_cnt  <= '0;
      rx_string <= '0;
      rx_length <= '0;
      rx_done   <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (idle_run) idle_cnt <= idle_cnt + 1'b1;
      else idle_cnt <= '0;
      if (start_ok) rx_busy <= 1'b1;

      if (terminate) begin
        rx_string <= work_buf;
        rx_length <= count;
        rx_done   <= 1'b1;
        rx_busy   <= 1'b0;
        work_buf  <= '0;
        count     <= '0;
        full      <= 1'b0;
        idle_cnt  <= '0;
      end else if (byte_vld && byte_data != 8'h0D) begin
        work_buf[{count[6:0], 3'b000} +: 8] <= byte_data;
        count <= count + 8'd1;
        full  <= (count == 8'd127);
      end else if (state == S_IDLE && !byte_vld && count == 8'd0) begin
        // Nothing held after an error or a dropped CR: drop busy back to idle
        rx_busy <= 1'b0;
      end
    end
  end

endmodule
